// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chess_pkg
//  Description : Shared board types, geometry constants and the per-axis
//                slide helper used by the piece motion controllers.
//  Revision    : 1.0
// ============================================================================
package chess_pkg;

    typedef logic [2:0] file_t;
    typedef logic [2:0] rank_t;

    localparam int SQ_PX    = 60;
    localparam int BOARD_X0 = 80;
    localparam int VBLANK_Y = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DONE   = 2'd2
    } motion_state_t;

    // One axis moves toward tgt by min(step, |tgt-cur|), so it never overshoots.
    function automatic logic [9:0] step_toward(
        input logic [9:0] cur,
        input logic [9:0] tgt,
        input logic [9:0] step
    );
        logic signed [10:0] diff;
        logic        [10:0] mag;
        logic        [9:0]  amt;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[10] ? 11'(-diff) : 11'(diff);
        amt  = (mag > {1'b0, step}) ? step : mag[9:0];
        step_toward = diff[10] ? (cur - amt) : (cur + amt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : One-cycle pulse at the start of vertical blank, taken from
//                the rising edge of (DrawX == 0 && DrawY == VBLANK_Y).
//  Revision    : 1.0
// ============================================================================
module frame_tick_gen
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic       o_frame_tick
);

    logic w_vblank_start;
    logic r_vblank_start_d;

    assign w_vblank_start = (i_draw_x == 10'd0) && (i_draw_y == 10'(VBLANK_Y));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblank_start_d <= 1'b0;
        end else begin
            r_vblank_start_d <= w_vblank_start;
        end
    end

    assign o_frame_tick = w_vblank_start && !r_vblank_start_d;

endmodule
`default_nettype wire

// File: rtl/piece_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : piece_motion_ctrl
//  Description : Per-piece square/position state; slides the sprite offsets
//                toward a commanded square, updating only on vblank ticks.
//                SMOOTH_SLIDE_EN selects stepped sliding; otherwise the
//                sprite snaps to the target on the first tick.
//  Revision    : 1.0
// ============================================================================
module piece_motion_ctrl #(
    parameter int INIT_FILE = 0,
    parameter int INIT_RANK = 0,
    parameter int SQ_PX     = 60,
    parameter int STEP_PX   = 4
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] move_file,
    input  logic [2:0] move_rank,
    input  logic       capture_req,
    input  logic       sel_set,
    input  logic       sel_clr,
    output logic [9:0] offsetX,
    output logic [9:0] offsetY,
    output logic       captured,
    output logic       selected,
    output logic [2:0] cur_file,
    output logic [2:0] cur_rank,
    output logic       busy,
    output logic       move_done
);

    localparam logic [9:0] c_init_x = 10'(INIT_FILE * SQ_PX);
    localparam logic [9:0] c_init_y = 10'(INIT_RANK * SQ_PX);
`ifdef SMOOTH_SLIDE_EN
    localparam logic [9:0] c_step   = 10'(STEP_PX);
`else
    // Larger than any on-screen distance, so the first tick lands on target.
    localparam logic [9:0] c_step   = 10'h3FF;
`endif

    if (STEP_PX < 1 || STEP_PX > SQ_PX) begin : g_step_px_range
        $error("piece_motion_ctrl: STEP_PX must lie in 1..SQ_PX");
    end

    chess_pkg::motion_state_t r_state;
    chess_pkg::motion_state_t w_state_nxt;

    chess_pkg::file_t r_file;
    chess_pkg::rank_t r_rank;
    logic [9:0]       r_off_x;
    logic [9:0]       r_off_y;
    logic [9:0]       r_tgt_x;
    logic [9:0]       r_tgt_y;
    logic             r_captured;
    logic             r_selected;
    logic             r_cap_pend;

    logic       w_tick;
    logic       w_accept;
    logic       w_arrive;
    logic       w_cap_set;
    logic [9:0] w_dest_x;
    logic [9:0] w_dest_y;
    logic [9:0] w_step_x;
    logic [9:0] w_step_y;

    frame_tick_gen u_frame_tick_gen (
        .clk          (vga_clk),
        .rst          (reset),
        .i_draw_x     (DrawX),
        .i_draw_y     (DrawY),
        .o_frame_tick (w_tick)
    );

    assign w_accept = (r_state == chess_pkg::IDLE) && move_valid && !r_captured;
    assign w_dest_x = 10'(int'(move_file) * SQ_PX);
    assign w_dest_y = 10'(int'(move_rank) * SQ_PX);
    assign w_step_x = chess_pkg::step_toward(r_off_x, r_tgt_x, c_step);
    assign w_step_y = chess_pkg::step_toward(r_off_y, r_tgt_y, c_step);
    assign w_arrive = (w_step_x == r_tgt_x) && (w_step_y == r_tgt_y);

    // A capture that arrives mid-move is deferred until the sprite has landed.
    assign w_cap_set = ((r_state == chess_pkg::IDLE)   && capture_req && !w_accept) ||
                       ((r_state == chess_pkg::MOVING) && w_tick && w_arrive &&
                        (r_cap_pend || capture_req)) ||
                       ((r_state == chess_pkg::DONE)   && capture_req);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state <= chess_pkg::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        move_ready  = 1'b0;
        busy        = 1'b0;
        move_done   = 1'b0;
        case (r_state)
            chess_pkg::IDLE: begin
                move_ready = !r_captured;
                if (move_valid && !r_captured) begin
                    w_state_nxt = chess_pkg::MOVING;
                end
            end
            chess_pkg::MOVING: begin
                busy = 1'b1;
                if (w_tick && w_arrive) begin
                    w_state_nxt = chess_pkg::DONE;
                end
            end
            chess_pkg::DONE: begin
                move_done   = 1'b1;
                w_state_nxt = chess_pkg::IDLE;
            end
            default: begin
                w_state_nxt = chess_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_off_x    <= c_init_x;
            r_off_y    <= c_init_y;
            r_tgt_x    <= c_init_x;
            r_tgt_y    <= c_init_y;
            r_file     <= 3'(INIT_FILE);
            r_rank     <= 3'(INIT_RANK);
            r_captured <= 1'b0;
            r_selected <= 1'b0;
            r_cap_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tgt_x <= w_dest_x;
                r_tgt_y <= w_dest_y;
                r_file  <= move_file;
                r_rank  <= move_rank;
            end

            if ((r_state == chess_pkg::MOVING) && w_tick) begin
                r_off_x <= w_step_x;
                r_off_y <= w_step_y;
            end

            if (w_cap_set) begin
                r_captured <= 1'b1;
            end

            if ((r_state == chess_pkg::MOVING) && w_tick && w_arrive) begin
                r_cap_pend <= 1'b0;
            end else if (capture_req &&
                         ((r_state == chess_pkg::MOVING) || w_accept)) begin
                r_cap_pend <= 1'b1;
            end

            if (sel_clr || w_accept || w_cap_set) begin
                r_selected <= 1'b0;
            end else if (sel_set && !r_captured && !busy) begin
                r_selected <= 1'b1;
            end
        end
    end

    assign offsetX  = r_off_x;
    assign offsetY  = r_off_y;
    assign captured = r_captured;
    assign selected = r_selected;
    assign cur_file = r_file;
    assign cur_rank = r_rank;

endmodule
`default_nettype wire
